// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   state_t        : loader FSM encoding (3-bit)
//   HDR_BYTES      : length of the word-count header in bytes
//   BYTES_PER_WORD : stream bytes packed into one imem word
package loader_pkg;

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DATA   = 3'd2,
    DONE   = 3'd3,
    ERR    = 3'd4
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: packs a byte stream into big-endian 32-bit words.
//   clk, reset : clock, asynchronous active-low reset
//   clr        : synchronous clear of the partial word and byte counter
//   push       : din is consumed this cycle
//   din        : stream byte
//   word       : packed word including the byte being pushed now
//   word_done  : push of the last byte of a word (combinational)
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_done
);

  logic [23:0] sr;
  logic [1:0]  cnt;

  // The current byte is combined in directly so the loader can register the
  // complete word on the same edge that accepts its final byte.
  assign word      = {sr, din};
  assign word_done = push && (cnt == 2'(BYTES_PER_WORD - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sr  <= '0;
      cnt <= '0;
    end else if (push) begin
      sr  <= {sr[15:0], din};
      cnt <= cnt + 2'd1;  // wraps 3 -> 0 at word boundary
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader in front of the MIPS instruction
// memory. Parses a 2-byte word count N (MSB first) followed by 4*N payload
// bytes, writes big-endian words from address 0, then releases the datapath.
//   clk, reset   : clock, asynchronous active-low reset (release assumed
//                  synchronous to clk upstream)
//   start        : re-arm pulse, honoured only in DONE/ERR
//   in_data/in_valid/in_ready : byte stream handshake
//   wr_en/wr_addr/wr_data     : imem write port, one strobe per word
//   words_loaded : words written since last arm
//   cpu_reset_n  : datapath reset, high only in DONE
//   busy, error  : status
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic                  cpu_reset_n,
  output logic                  busy,
  output logic                  error
);

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t                state;
  logic [15:0]           n_words;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  accept;
  logic                  rearm;
  logic [31:0]           packed_word;
  logic                  word_done;
  logic [15:0]           n_full;
  logic [15:0]           next_count;

  // Ready depends on state alone so upstream never sees a valid->ready loop.
  assign busy     = (state == HDR_HI) || (state == HDR_LO) || (state == DATA);
  assign in_ready = busy;
  assign accept   = in_valid && in_ready;
  assign rearm    = start && ((state == DONE) || (state == ERR));

  assign n_full     = {n_words[15:8], in_data};
  assign next_count = 16'(words_loaded) + 16'd1;

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (rearm),
    .push      (accept && (state == DATA)),
    .din       (in_data),
    .word      (packed_word),
    .word_done (word_done)
  );

  // NOTE: asynchronous active-low reset puts every flop in a known state the
  // moment reset falls, so cpu_reset_n drops without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= HDR_HI;
      n_words      <= '0;
      word_idx     <= '0;
      words_loaded <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      cpu_reset_n  <= 1'b0;
      error        <= 1'b0;
    end else begin
      // NOTE: default the strobe low first so it can only ever last one cycle.
      wr_en <= 1'b0;
      unique case (state)
        HDR_HI: if (accept) begin
          n_words[15:8] <= in_data;
          state         <= HDR_LO;
        end
        HDR_LO: if (accept) begin
          n_words[7:0] <= in_data;
          if (n_full == 16'd0 || {1'b0, n_full} > MAX_N) begin
            state <= ERR;
            error <= 1'b1;
          end else begin
            state <= DATA;
          end
        end
        DATA: if (word_done) begin
          wr_en        <= 1'b1;
          wr_addr      <= word_idx;
          wr_data      <= packed_word;
          word_idx     <= word_idx + 1'b1;
          words_loaded <= words_loaded + 1'b1;
          if (next_count == n_words) state <= DONE;
        end
        DONE, ERR: begin
          // Release the datapath one cycle after the final write lands.
          cpu_reset_n <= (state == DONE) && !start;
          if (start) begin
            state        <= HDR_HI;
            word_idx     <= '0;
            words_loaded <= '0;
            error        <= 1'b0;
          end
        end
        default: state <= HDR_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected imem writes are queued when
// payload is driven and retired by a monitor watching the write port.
module tb_imem_loader;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [AW:0]   words_loaded;
  logic          cpu_reset_n;
  logic          busy;
  logic          error;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img [4];
  logic [AW-1:0] next_addr;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .words_loaded(words_loaded), .cpu_reset_n(cpu_reset_n),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Write-port monitor: every strobe must match the oldest queued write.
  always @(negedge clk) begin
    if (wr_en) begin
      wr_t got, want;
      got = '{addr: wr_addr, data: wr_data};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr=%0h data=%08h, required no write", wr_addr, wr_data);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_err++;
          $display("FAIL write: got addr=%0h data=%08h, required addr=%0h data=%08h",
                   got.addr, got.data, want.addr, want.data);
        end
      end
    end
  end

  task automatic expect1(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  // Drives one byte from posedge+1 and returns at posedge+1 after acceptance.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc;
    int budget;
    acc = 1'b0;
    budget = 50;
    in_data  = b;
    in_valid = 1'b1;
    while (!acc && budget > 0) begin
      acc = in_ready;
      @(posedge clk); #1;
      budget--;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL byte_timeout: byte %02h not accepted within 50 cycles, required acceptance", b);
    end
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_header(input logic [15:0] n, input bit gap);
    send_byte(n[15:8], gap);
    send_byte(n[7:0], gap);
  endtask

  // Loads img[0..n-1]; queues each expected write as its payload is driven.
  task automatic load_image(input int n, input bit gap);
    send_header(16'(n), gap);
    for (int w = 0; w < n; w++) begin
      exp_q.push_back('{addr: AW'(w), data: img[w]});
      for (int b = 3; b >= 0; b--) send_byte(img[w][8*b +: 8], gap && !(w == n-1 && b == 0));
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect1("rst_cpu_reset_n", 32'(cpu_reset_n), 0);
    expect1("rst_in_ready", 32'(in_ready), 1);
    expect1("rst_wr_en", 32'(wr_en), 0);
    expect1("rst_words_loaded", 32'(words_loaded), 0);
    expect1("rst_wr_addr_data", {wr_data[23:0], wr_addr}, 0);
    expect1("rst_error", 32'(error), 0);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_normal_load();
    img[0] = 32'h20080005;
    img[1] = 32'hAC080004;
    load_image(2, 1'b0);
    // Now in the cycle of the final write strobe.
    expect1("nrm_last_wr_en", 32'(wr_en), 1);
    expect1("nrm_cpu_held", 32'(cpu_reset_n), 0);
    @(posedge clk); #1;
    expect1("nrm_cpu_released", 32'(cpu_reset_n), 1);
    expect1("nrm_words_loaded", 32'(words_loaded), 2);
    expect1("nrm_in_ready_done", 32'(in_ready), 0);
    expect1("nrm_queue_drained", exp_q.size(), 0);
    repeat (2) @(posedge clk); #1;
    expect1("nrm_words_hold", 32'(words_loaded), 2);
    expect1("nrm_addr_hold", {wr_addr, wr_data[23:0]}, {8'h01, 24'h080004});
  endtask

  task automatic test_rearm();
    // start arrives together with a byte that would be an illegal N_hi.
    in_data  = 8'hFF;
    in_valid = 1'b1;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    expect1("rearm_cpu_reset_n", 32'(cpu_reset_n), 0);
    expect1("rearm_in_ready", 32'(in_ready), 1);
    expect1("rearm_words_cleared", 32'(words_loaded), 0);
    img[0] = 32'h12345678;
    load_image(1, 1'b0);
    @(posedge clk); #1;
    expect1("rearm_done_error", 32'(error), 0);
    expect1("rearm_words_loaded", 32'(words_loaded), 1);
    expect1("rearm_cpu_released", 32'(cpu_reset_n), 1);
  endtask

  task automatic test_gaps();
    pulse_start();
    img[0] = 32'h20080005;
    img[1] = 32'hAC080004;
    load_image(2, 1'b1);
    @(posedge clk); #1;
    expect1("gap_words_loaded", 32'(words_loaded), 2);
    expect1("gap_queue_drained", exp_q.size(), 0);
    expect1("gap_cpu_released", 32'(cpu_reset_n), 1);
  endtask

  task automatic test_header_err();
    logic [15:0] bad [2];
    bad[0] = 16'h0000;
    bad[1] = 16'h0101;
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      send_header(bad[i], 1'b0);
      repeat (2) @(posedge clk); #1;
      expect1($sformatf("err_flag_%04h", bad[i]), 32'(error), 1);
      expect1($sformatf("err_in_ready_%04h", bad[i]), 32'(in_ready), 0);
      expect1($sformatf("err_cpu_held_%04h", bad[i]), 32'(cpu_reset_n), 0);
      expect1($sformatf("err_no_words_%04h", bad[i]), 32'(words_loaded), 0);
      pulse_start();
      expect1($sformatf("err_cleared_%04h", bad[i]), {31'(error), in_ready}, 1);
    end
    // N == MAX_WORDS is the largest legal count.
    send_header(16'h0100, 1'b0);
    expect1("max_n_accepted", {30'(error), busy, in_ready}, 3);
  endtask

  task automatic test_reset_mid_word();
    // Leave the pending MAX_WORDS load with two payload bytes of word 0.
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    reset = 1'b0;
    #1;
    expect1("mid_cpu_reset_async", 32'(cpu_reset_n), 0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    expect1("mid_after_reset_words", 32'(words_loaded), 0);
    img[0] = 32'hDEADBEEF;
    load_image(1, 1'b0);
    @(posedge clk); #1;
    expect1("mid_reload_words", 32'(words_loaded), 1);
    expect1("mid_reload_cpu", 32'(cpu_reset_n), 1);
    expect1("mid_reload_addr_data", wr_data, 32'hDEADBEEF);
  endtask

  initial begin
    test_reset();
    test_normal_load();
    test_rearm();
    test_gaps();
    test_header_err();
    test_reset_mid_word();
    repeat (2) @(posedge clk); #1;
    expect1("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
